// File: rtl/rx_combine_pkg.sv
// Shared widths, LLR clamp limits and FSM encodings for the HARQ soft-combining path.
package rx_combine_pkg;

  localparam int LLR_W      = 6;
  localparam int LANES      = 16;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = LANES * LLR_W;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int WIDX_W     = 16 - LANE_IDX_W;

  // Symmetric clamp: the most negative code is never written back.
  localparam logic signed [LLR_W-1:0] LLR_MAX = LLR_W'(2 ** (LLR_W - 1) - 1);
  localparam logic signed [LLR_W-1:0] LLR_MIN = -LLR_MAX;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/llr_sat_add.sv
// One lane of the combiner: signed add of new and stored LLR with symmetric clamp.
// A disabled lane passes the stored value through and never reports saturation.
module llr_sat_add
  import rx_combine_pkg::*;
(
  input  logic signed [LLR_W-1:0] i_new,
  input  logic signed [LLR_W-1:0] i_old,
  input  logic                    i_en,
  output logic signed [LLR_W-1:0] o_res,
  output logic                    o_sat
);

  localparam logic signed [LLR_W:0] SUM_HI = {LLR_MAX[LLR_W-1], LLR_MAX};
  localparam logic signed [LLR_W:0] SUM_LO = {LLR_MIN[LLR_W-1], LLR_MIN};

  logic signed [LLR_W:0] sum;

  always_comb begin
    sum   = {i_new[LLR_W-1], i_new} + {i_old[LLR_W-1], i_old};
    o_res = i_old;
    o_sat = 1'b0;
    if (i_en) begin
      if (sum > SUM_HI) begin
        o_res = LLR_MAX;
        o_sat = 1'b1;
      end else if (sum < SUM_LO) begin
        o_res = LLR_MIN;
        o_sat = 1'b1;
      end else begin
        o_res = sum[LLR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rdm_harq_combine.sv
// Soft-combines rate-dematched LLR words into the per-user circular HARQ buffer
// with a two-stage read-modify-write pipeline over a 1-cycle-latency SDP RAM.
module rdm_harq_combine
  import rx_combine_pkg::*;
(
  input  logic              i_core_clk,
  input  logic              i_rx_rstn,
  input  logic              i_Combine_process_request,
  input  logic [15:0]       i_Current_Combine_Ncb_Size,
  input  logic [ADDR_W-1:0] i_Harq_Base_Addr,
  input  logic              i_Harq_First_Tx,
  output logic              o_RDM_Data_Request,
  input  logic              i_RDM_Data_Valid,
  input  logic [DATA_W-1:0] i_RDM_Data_Content,
  input  logic              i_RDM_Data_Comp,
  output logic              o_Harq_Rd_En,
  output logic [ADDR_W-1:0] o_Harq_Rd_Addr,
  input  logic [DATA_W-1:0] i_Harq_Rd_Data,
  output logic              o_Harq_Wr_En,
  output logic [ADDR_W-1:0] o_Harq_Wr_Addr,
  output logic [DATA_W-1:0] o_Harq_Wr_Data,
  output logic              o_Combine_Busy,
  output logic              o_Combine_Comp,
  output logic [15:0]       o_Sat_Count
);

  state_t              state_q, state_d;
  logic [15:0]         ncb_q, ncb_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                first_tx_q, first_tx_d;
  logic                wrapped_q, wrapped_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                comp_prev_q, comp_prev_d;
  logic [15:0]         sat_cnt_q, sat_cnt_d;

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_fresh_q, s1_fresh_d;
  logic                bypass_q, bypass_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                start;
  logic                accept;
  logic                last_word;
  logic                comp_rise;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   sum_word;
  logic [LANES-1:0]    lane_en;
  logic [LANES-1:0]    lane_sat;
  logic [LANE_IDX_W:0] n_sat;
  logic [16:0]         sat_sum;

  assign start     = (state_q == ST_IDLE) && i_Combine_process_request;
  assign accept    = (state_q == ST_RUN) && i_RDM_Data_Valid;
  assign last_word = (widx_q == ncb_q[15:LANE_IDX_W]);
  assign comp_rise = i_RDM_Data_Comp && !comp_prev_q;
  assign rd_addr   = base_q + ADDR_W'(widx_q);

  // First pass of a first transmission ignores RAM; repetitions and bypass see this user's writes.
  always_comb begin
    if (s1_fresh_q) begin
      old_word = '0;
    end else if (bypass_q) begin
      old_word = wr_data_q;
    end else begin
      old_word = i_Harq_Rd_Data;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_en[k] = !s1_last_q || (LANE_IDX_W'(k) <= ncb_q[LANE_IDX_W-1:0]);

    llr_sat_add u_add (
      .i_new (s1_data_q[k*LLR_W +: LLR_W]),
      .i_old (old_word[k*LLR_W +: LLR_W]),
      .i_en  (lane_en[k]),
      .o_res (sum_word[k*LLR_W +: LLR_W]),
      .o_sat (lane_sat[k])
    );
  end

  always_comb begin
    n_sat = '0;
    for (int k = 0; k < LANES; k++) begin
      n_sat = n_sat + (LANE_IDX_W + 1)'(lane_sat[k]);
    end
    sat_sum = {1'b0, sat_cnt_q} + 17'(n_sat);
  end

  always_comb begin
    state_d     = state_q;
    ncb_d       = ncb_q;
    base_d      = base_q;
    first_tx_d  = first_tx_q;
    wrapped_d   = wrapped_q;
    widx_d      = widx_q;
    comp_prev_d = start ? 1'b0 : i_RDM_Data_Comp;
    sat_cnt_d   = sat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Combine_process_request) begin
          state_d    = ST_RUN;
          ncb_d      = i_Current_Combine_Ncb_Size;
          base_d     = i_Harq_Base_Addr;
          first_tx_d = i_Harq_First_Tx;
          wrapped_d  = 1'b0;
          widx_d     = '0;
          sat_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (comp_rise) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      widx_d = last_word ? '0 : widx_q + 1'b1;
      if (last_word) begin
        wrapped_d = 1'b1;
      end
    end

    if (s1_valid_q) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  // Stage 0 -> stage 1 hand-off; bypass flags a read of the address being written this cycle.
  always_comb begin
    s1_valid_d = accept;
    s1_data_d  = accept ? i_RDM_Data_Content : s1_data_q;
    s1_addr_d  = accept ? rd_addr : s1_addr_q;
    s1_last_d  = accept ? last_word : s1_last_q;
    s1_fresh_d = accept ? (first_tx_q && !wrapped_q) : s1_fresh_q;
    bypass_d   = accept && s1_valid_q && (rd_addr == s1_addr_q);
    wr_data_d  = s1_valid_q ? sum_word : wr_data_q;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q     <= ST_IDLE;
      ncb_q       <= '0;
      base_q      <= '0;
      first_tx_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      widx_q      <= '0;
      comp_prev_q <= 1'b0;
      sat_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_addr_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_fresh_q  <= 1'b0;
      bypass_q    <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ncb_q       <= ncb_d;
      base_q      <= base_d;
      first_tx_q  <= first_tx_d;
      wrapped_q   <= wrapped_d;
      widx_q      <= widx_d;
      comp_prev_q <= comp_prev_d;
      sat_cnt_q   <= sat_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_addr_q   <= s1_addr_d;
      s1_last_q   <= s1_last_d;
      s1_fresh_q  <= s1_fresh_d;
      bypass_q    <= bypass_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign o_RDM_Data_Request = (state_q == ST_RUN);
  assign o_Combine_Busy     = (state_q != ST_IDLE);
  assign o_Combine_Comp     = (state_q == ST_DONE);
  assign o_Harq_Rd_En       = accept;
  assign o_Harq_Rd_Addr     = accept ? rd_addr : '0;
  assign o_Harq_Wr_En       = s1_valid_q;
  assign o_Harq_Wr_Addr     = s1_valid_q ? s1_addr_q : '0;
  assign o_Harq_Wr_Data     = s1_valid_q ? sum_word : '0;
  assign o_Sat_Count        = sat_cnt_q;

endmodule

// File: tb/tb_rdm_harq_combine.sv
// Bench for rdm_harq_combine: directed vector table, hand-written reset/idle sequences,
// and randomized users checked against a lane-by-lane reference of the circular buffer.
module tb_rdm_harq_combine;
  import rx_combine_pkg::*;

  localparam int DW    = DATA_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct {
    logic [15:0]       ncb;
    logic [ADDR_W-1:0] base;
    bit                ftx;
    int                nwords;
    int                new_val;
    int                pre_val;
    bit                comp_last;
    int                exp_sat;
    int                exp_lane0;
    int                exp_lane15;
    logic [ADDR_W-1:0] exp_last_addr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req = 1'b0;
  logic [15:0]       ncb_i = '0;
  logic [ADDR_W-1:0] base_i = '0;
  logic              ftx_i = 1'b0;
  logic              rdm_req;
  logic              valid = 1'b0;
  logic [DW-1:0]     content = '0;
  logic              comp = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic              busy;
  logic              done;
  logic [15:0]       sat_cnt;

  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DW-1:0]     bd_data = '0;

  logic [DW-1:0]     ram [0:DEPTH-1];
  int                ref_llr [0:DEPTH-1][0:LANES-1];
  logic [DW-1:0]     word_q[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_sat;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  rdm_harq_combine dut (
    .i_core_clk                 (clk),
    .i_rx_rstn                  (rstn),
    .i_Combine_process_request  (req),
    .i_Current_Combine_Ncb_Size (ncb_i),
    .i_Harq_Base_Addr           (base_i),
    .i_Harq_First_Tx            (ftx_i),
    .o_RDM_Data_Request         (rdm_req),
    .i_RDM_Data_Valid           (valid),
    .i_RDM_Data_Content         (content),
    .i_RDM_Data_Comp            (comp),
    .o_Harq_Rd_En               (rd_en),
    .o_Harq_Rd_Addr             (rd_addr),
    .i_Harq_Rd_Data             (rd_data),
    .o_Harq_Wr_En               (wr_en),
    .o_Harq_Wr_Addr             (wr_addr),
    .o_Harq_Wr_Data             (wr_data),
    .o_Combine_Busy             (busy),
    .o_Combine_Comp             (done),
    .o_Sat_Count                (sat_cnt)
  );

  // SDP RAM model: 1-cycle read latency, a read colliding with a write returns the old word.
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
      wr_addr_log.push_back(wr_addr);
    end
    if (bd_we) ram[bd_addr] <= bd_data;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lane_val(input logic [DW-1:0] w, input int k);
    logic signed [LLR_W-1:0] v;
    v = w[k*LLR_W +: LLR_W];
    return int'(v);
  endfunction

  function automatic logic [DW-1:0] uniform_word(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LLR_W +: LLR_W] = LLR_W'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] random_word();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LLR_W +: LLR_W] = LLR_W'($urandom_range(0, 63));
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_word(input int a);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LLR_W +: LLR_W] = LLR_W'(ref_llr[a][k]);
    return r;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] base, input int nw, input bit rnd, input int val);
    int a, v;
    logic [DW-1:0] w;
    for (int i = 0; i < nw; i++) begin
      a = (int'(base) + i) % DEPTH;
      for (int k = 0; k < LANES; k++) begin
        v = rnd ? int'($urandom_range(0, 63)) - 32 : val;
        ref_llr[a][k] = v;
        w[k*LLR_W +: LLR_W] = LLR_W'(v);
      end
      @(negedge clk);
      bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = w;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Reference: word i lands on buffer word i mod N_W; the first pass of a first transmission starts from zero.
  task automatic ref_combine(input logic [15:0] ncb, input logic [ADDR_W-1:0] base, input bit ftx);
    int nw, lastn, w, a, ov, s;
    nw = int'(ncb[15:4]) + 1;
    lastn = int'(ncb[3:0]) + 1;
    exp_addr.delete();
    exp_sat = 0;
    for (int i = 0; i < word_q.size(); i++) begin
      w = i % nw;
      a = (int'(base) + w) % DEPTH;
      exp_addr.push_back(ADDR_W'(a));
      for (int k = 0; k < LANES; k++) begin
        ov = (ftx && i < nw) ? 0 : ref_llr[a][k];
        if (w == nw - 1 && k >= lastn) begin
          ref_llr[a][k] = ov;
        end else begin
          s = lane_val(word_q[i], k) + ov;
          if (s > 31) begin s = 31; exp_sat++; end
          else if (s < -31) begin s = -31; exp_sat++; end
          ref_llr[a][k] = s;
        end
      end
    end
    if (exp_sat > 65535) exp_sat = 65535;
  endtask

  task automatic applyStimulus(input logic [15:0] ncb, input logic [ADDR_W-1:0] base, input logic ftx,
                               input int gap_pct, input bit comp_last, input bit stray_req);
    int cnt, gaps;
    wr_addr_log.delete();
    @(negedge clk);
    req = 1'b1; ncb_i = ncb; base_i = base; ftx_i = ftx;
    @(negedge clk);
    req = 1'b0;
    checkOutput("run_request", DW'(rdm_req), DW'(1));
    for (int i = 0; i < word_q.size(); i++) begin
      gaps = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 2)) : 0;
      repeat (gaps) begin
        valid = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1;
      content = word_q[i];
      if (stray_req && i == 1) begin
        req = 1'b1; base_i = base + ADDR_W'(5); ncb_i = ~ncb;
      end
      if (comp_last && i == word_q.size() - 1) comp = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    valid = 1'b0;
    comp = 1'b1;
    cnt = comp_last ? 1 : 0;
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("comp_latency", DW'(cnt), DW'(2));
    @(negedge clk);
    checkOutput("idle_after_done", DW'({done, busy}), DW'(0));
    comp = 1'b0;
  endtask

  task automatic verify_run(input logic [15:0] ncb, input logic [ADDR_W-1:0] base);
    int nw;
    logic [ADDR_W-1:0] a;
    checkOutput("sat_count", DW'(sat_cnt), DW'(exp_sat));
    checkOutput("write_count", DW'(wr_addr_log.size()), DW'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr_log.size(); i++)
      checkOutput("write_addr", DW'(wr_addr_log[i]), DW'(exp_addr[i]));
    nw = int'(ncb[15:4]) + 1;
    for (int w = 0; w < nw; w++) begin
      a = base + ADDR_W'(w);
      checkOutput("ram_word", ram[a], ref_word(int'(a)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] ncb;
    logic [ADDR_W-1:0] base, last_a;
    bit ftx;
    int nw, nwords;

    vecs[0] = '{16'd63, 12'h100, 1'b1, 4,  5,   7, 1'b0,  0,  5,   5, 12'h103};
    vecs[1] = '{16'd31, 12'h200, 1'b0, 4, 20,  20, 1'b1, 64, 31,  31, 12'h201};
    vecs[2] = '{16'd5,  12'h300, 1'b1, 3, 10,   0, 1'b0,  0, 30,   0, 12'h300};
    vecs[3] = '{16'd15, 12'h400, 1'b0, 1, -32, -32, 1'b0, 16, -31, -31, 12'h400};
    vecs[4] = '{16'd15, 12'h410, 1'b0, 1, 31, -31, 1'b0,  0,  0,   0, 12'h410};
    vecs[5] = '{16'd31, 12'hFFF, 1'b1, 2,  3,   0, 1'b1,  0,  3,   3, 12'h000};

    #12;
    checkOutput("reset_outputs", DW'({rdm_req, busy, done, rd_en, wr_en, sat_cnt, rd_addr, wr_addr}), DW'(0));
    checkOutput("reset_wr_data", wr_data, '0);
    @(negedge clk);
    rstn = 1'b1;

    @(negedge clk);
    valid = 1'b1;
    content = uniform_word(7);
    #1;
    checkOutput("idle_no_read", DW'(rd_en), DW'(0));
    @(negedge clk);
    valid = 1'b0;
    checkOutput("idle_no_write", DW'({wr_en, busy}), DW'(0));

    for (int t = 0; t < 6; t++) begin
      word_q.delete();
      repeat (vecs[t].nwords) word_q.push_back(uniform_word(vecs[t].new_val));
      nw = int'(vecs[t].ncb[15:4]) + 1;
      preload(vecs[t].base, nw, 1'b0, vecs[t].pre_val);
      ref_combine(vecs[t].ncb, vecs[t].base, vecs[t].ftx);
      applyStimulus(vecs[t].ncb, vecs[t].base, vecs[t].ftx, 0, vecs[t].comp_last, 1'b0);
      verify_run(vecs[t].ncb, vecs[t].base);
      checkOutput("tbl_sat", DW'(sat_cnt), DW'(vecs[t].exp_sat));
      checkOutput("tbl_lane0", DW'(lane_val(ram[vecs[t].base], 0)), DW'(vecs[t].exp_lane0));
      checkOutput("tbl_lane15", DW'(lane_val(ram[vecs[t].base], 15)), DW'(vecs[t].exp_lane15));
      last_a = (wr_addr_log.size() > 0) ? wr_addr_log[wr_addr_log.size() - 1] : '1;
      checkOutput("tbl_last_addr", DW'(last_a), DW'(vecs[t].exp_last_addr));
    end

    // Reset in the middle of a user, then the same user reissued as a first transmission.
    word_q.delete();
    repeat (4) word_q.push_back(random_word());
    @(negedge clk);
    req = 1'b1; ncb_i = 16'd63; base_i = 12'h500; ftx_i = 1'b1;
    @(negedge clk);
    req = 1'b0; valid = 1'b1; content = word_q[0];
    @(negedge clk);
    content = word_q[1];
    @(negedge clk);
    content = word_q[2];
    #1;
    checkOutput("pre_reset_write", DW'({wr_en, busy}), DW'(2'b11));
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("midrun_reset_outputs", DW'({rdm_req, busy, done, rd_en, wr_en, sat_cnt, rd_addr, wr_addr}), DW'(0));
    checkOutput("midrun_reset_wr_data", wr_data, '0);
    @(negedge clk);
    valid = 1'b0;
    rstn = 1'b1;
    ref_combine(16'd63, 12'h500, 1'b1);
    applyStimulus(16'd63, 12'h500, 1'b1, 0, 1'b0, 1'b0);
    verify_run(16'd63, 12'h500);

    for (int r = 0; r < 20; r++) begin
      ncb = 16'($urandom_range(0, 255));
      base = ADDR_W'($urandom);
      ftx = 1'($urandom_range(0, 1));
      nw = int'(ncb[15:4]) + 1;
      nwords = $urandom_range(1, 3 * nw);
      if (nwords > 40) nwords = 40;
      word_q.delete();
      repeat (nwords) word_q.push_back(random_word());
      preload(base, nw, 1'b1, 0);
      ref_combine(ncb, base, ftx);
      applyStimulus(ncb, base, ftx, ($urandom_range(0, 1) == 1) ? 30 : 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      verify_run(ncb, base);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
